// File: rtl/pixel_pipe_reg_pkg.sv
// Shared constants and helpers for the elastic pixel register pipeline.
package pixel_pipe_reg_pkg;

    // Beyond this depth the combinational ready chain gets long; chain instances instead.
    localparam int MAX_DEPTH = 8;

    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pixel_pipe_reg_stage.sv
// One pipeline slot: a valid flag plus its data word.
module pipe_stage
    import pixel_pipe_reg_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             move,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Clear wins over load; a slot that only drains becomes empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid <= 1'b0;
        else if (clear)
            valid <= 1'b0;
        else if (load)
            valid <= 1'b1;
        else if (move)
            valid <= 1'b0;
    end

    // Data only changes on an actual load, so a stalled word stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data <= INIT;
        else if (load && !clear)
            data <= load_data;
    end

endmodule

// File: rtl/pixel_pipe_reg.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake and flush.
module pixel_pipe_reg
    import pixel_pipe_reg_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             in_valid,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [WIDTH-1:0]                 out_data,
    input  logic                             out_ready,
    output logic [count_width(DEPTH)-1:0]    count
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] mv;
    logic [WIDTH-1:0] d [DEPTH];
    logic             accept;
    logic             emit;

    // A stage moves on when the stage ahead is empty or itself moving.
    always_comb begin : move_chain
        logic [DEPTH-1:0] m;
        m = '0;
        m[DEPTH-1] = v[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--)
            m[i] = v[i] & (!v[i+1] | m[i+1]);
        mv = m;
    end

    assign in_ready  = (!v[0] | mv[0]) & !clear;
    assign accept    = in_valid & in_ready;
    assign emit      = mv[DEPTH-1];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            pipe_stage #(.WIDTH(WIDTH), .INIT(INIT)) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .clear     (clear),
                .load      (accept),
                .move      (mv[i]),
                .load_data (in_data),
                .valid     (v[i]),
                .data      (d[i])
            );
        end else begin : g_rest
            pipe_stage #(.WIDTH(WIDTH), .INIT(INIT)) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .clear     (clear),
                .load      (mv[i-1]),
                .move      (mv[i]),
                .load_data (d[i-1]),
                .valid     (v[i]),
                .data      (d[i])
            );
        end
    end

    // Occupancy tracks the valid bits: one in per accept, one out per emit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else
            count <= count + CW'(accept) - CW'(emit);
    end

endmodule

// File: tb/tb_pixel_pipe_reg.sv
// Randomised and directed bench for pixel_pipe_reg against a word-queue reference model.
module tb_pixel_pipe_reg;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] INIT  = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] count;

    pixel_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passed = 0;
    bit         compare_en = 0;

    // Reference: held words oldest-first, each with its stage position.
    logic [7:0] mq[$];
    int         pq[$];
    bit         mvs[$];
    logic [7:0] last_out = INIT;

    logic       acc;
    logic       em;
    logic [7:0] ed;
    int         sent;
    int         got;
    int         cyc;
    int         first_acc;
    int         first_out;
    int         last_emit;
    logic [7:0] expq[$];

    function automatic void compute_moves(input logic rdy);
        mvs.delete();
        for (int k = 0; k < mq.size(); k++) begin
            if (k == 0)
                mvs.push_back((pq[0] == DEPTH - 1) ? rdy : 1'b1);
            else
                mvs.push_back((pq[k] + 1 < pq[k-1]) || mvs[k-1]);
        end
    endfunction

    function automatic logic model_ready(input logic rdy, input logic clr);
        compute_moves(rdy);
        if (clr) return 1'b0;
        if (mq.size() == 0) return 1'b1;
        return (pq[mq.size()-1] != 0) || mvs[mq.size()-1];
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic       a;
        logic [7:0] nq[$];
        int         np[$];
        int         p;
        if (!rst_n) begin
            mq.delete();
            pq.delete();
            last_out = INIT;
        end else begin
            a = in_valid && model_ready(out_ready, clear);
            if (clear) begin
                mq.delete();
                pq.delete();
            end else begin
                nq.delete();
                np.delete();
                for (int k = 0; k < mq.size(); k++) begin
                    if (!(k == 0 && pq[0] == DEPTH - 1 && mvs[0])) begin
                        p = pq[k] + (mvs[k] ? 1 : 0);
                        if (mvs[k] && p == DEPTH - 1) last_out = mq[k];
                        nq.push_back(mq[k]);
                        np.push_back(p);
                    end
                end
                if (a) begin
                    nq.push_back(in_data);
                    np.push_back(0);
                    if (DEPTH == 1) last_out = in_data;
                end
                mq = nq;
                pq = np;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (compare_en) begin
            checkOutput("out_valid", 32'(out_valid), 32'(mq.size() > 0 && pq[0] == DEPTH - 1));
            checkOutput("out_data", 32'(out_data), 32'(last_out));
            checkOutput("count", 32'(count), 32'(mq.size()));
            checkOutput("in_ready", 32'(in_ready), 32'(model_ready(out_ready, clear)));
        end
    end

    task automatic applyStimulus(input logic iv, input logic [7:0] id, input logic ordy,
                                 input logic clr, output logic a, output logic e,
                                 output logic [7:0] eword);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        clear     = clr;
        @(negedge clk);
        a     = in_valid & in_ready;
        e     = out_valid & out_ready;
        eword = out_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clk = 0;
        rst_n = 1;
        clear = 0;
        in_valid = 0;
        in_data = 0;
        out_ready = 0;

        #2 rst_n = 0;
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'hA5);
        checkOutput("reset_count", 32'(count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        compare_en = 1;
        #1;
        checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

        // Streaming 0x01..0x10 with the output always ready.
        sent = 0; got = 0; first_acc = -1; first_out = -1; last_emit = -1;
        for (cyc = 0; cyc < 60 && got < 16; cyc++) begin
            applyStimulus(sent < 16, 8'(sent + 1), 1'b1, 1'b0, acc, em, ed);
            if (acc) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            if (em) begin
                if (first_out < 0) first_out = cyc;
                last_emit = cyc;
                got++;
                checkOutput("stream_word", 32'(ed), 32'(got));
            end
        end
        checkOutput("stream_count", 32'(got), 32'd16);
        checkOutput("stream_latency", 32'(first_out - first_acc), 32'd3);
        checkOutput("stream_rate", 32'(last_emit - first_out), 32'd15);

        // Stall and fill with five offers against a blocked output.
        sent = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h31 + sent), 1'b0, 1'b0, acc, em, ed);
            if (acc) sent++;
        end
        checkOutput("fill_accepted", 32'(sent), 32'd3);
        checkOutput("fill_count", 32'(count), 32'd3);
        checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
        checkOutput("fill_head", 32'(out_data), 32'h31);
        applyStimulus(1'b1, 8'h34, 1'b0, 1'b0, acc, em, ed);
        checkOutput("fill_head_stable", 32'(out_data), 32'h31);

        // Full pipeline: accept and emit in the same cycle.
        expq = '{8'h31, 8'h32, 8'h33, 8'h41};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h41 + i), 1'b1, 1'b0, acc, em, ed);
            checkOutput("full_accept", 32'(acc), 32'd1);
            checkOutput("full_emit", 32'(em), 32'd1);
            checkOutput("full_word", 32'(ed), 32'(expq[i]));
        end
        repeat (6) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc, em, ed);

        // Flush with two words held and a word offered alongside.
        applyStimulus(1'b1, 8'h51, 1'b0, 1'b0, acc, em, ed);
        applyStimulus(1'b1, 8'h52, 1'b0, 1'b0, acc, em, ed);
        checkOutput("pre_clear_count", 32'(count), 32'd2);
        applyStimulus(1'b1, 8'h53, 1'b0, 1'b1, acc, em, ed);
        checkOutput("clear_rejects", 32'(acc), 32'd0);
        checkOutput("clear_count", 32'(count), 32'd0);
        checkOutput("clear_out_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc, em, ed);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 31) == 0, acc, em, ed);

        // Asynchronous reset between edges while streaming.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 8'(8'h61 + i), 1'b1, 1'b0, acc, em, ed);
        #2 rst_n = 0;
        #1;
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_out_data", 32'(out_data), 32'hA5);
        checkOutput("async_count", 32'(count), 32'd0);
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc, em, ed);
            checkOutput("no_stale", 32'(out_valid), 32'd0);
        end

        compare_en = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
